// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode encodings and depth helper.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_SIZE-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_SIZE-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// thresholds, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_SIZE     = 4,
  parameter int FWFT          = int'(FIFO_STD),
  parameter int AFULL_THRESH  = fifo_depth(ADDR_SIZE) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_SIZE:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);
  localparam logic [ADDR_SIZE:0] AFULL_L  = (ADDR_SIZE+1)'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] AEMPTY_L = (ADDR_SIZE+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_SIZE:0] PTR_ONE  = (ADDR_SIZE+1)'(1);

  if (!(AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_fwft: thresholds must satisfy AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [ADDR_SIZE:0]    wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc, rd_acc;

  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]) &&
                        (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]);
  assign almost_full  = (count >= AFULL_L);
  assign almost_empty = (count <= AEMPTY_L);

  // Flush and reset win over any request in the same cycle, so gate here to keep memory untouched.
  assign wr_acc = rstn && !flush && wr_en && !full;
  assign rd_acc = rstn && !flush && rd_en && !empty;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_SIZE-1:0]),
    .wdata (din),
    .raddr (rd_ptr[ADDR_SIZE-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dout_q    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        if (rd_acc && FWFT == int'(FIFO_STD)) dout_q <= mem_rdata;
      end

      if (!flush && wr_en && full) overflow <= 1'b1;
      else if (err_clr)            overflow <= 1'b0;

      if (!flush && rd_en && empty) underflow <= 1'b1;
      else if (err_clr)             underflow <= 1'b0;
    end
  end

  assign dout = (FWFT == int'(FIFO_FWFT)) ? mem_rdata : dout_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench: one stimulus stream drives a standard-mode and an FWFT-mode FIFO side by side.
module tb_sync_fifo_fwft;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, flush, wr_en, rd_en, err_clr;
  logic [15:0] din;

  logic [15:0] dout0, dout1;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic        full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]  count0, count1;

  sync_fifo_fwft #(
    .DATA_WIDTH (16), .ADDR_SIZE (4), .FWFT (0), .AFULL_THRESH (14), .AEMPTY_THRESH (2)
  ) dut0 (
    .clk (clk), .rstn (rstn), .flush (flush), .wr_en (wr_en), .din (din), .rd_en (rd_en),
    .dout (dout0), .full (full0), .empty (empty0), .almost_full (af0), .almost_empty (ae0),
    .count (count0), .overflow (ovf0), .underflow (unf0), .err_clr (err_clr)
  );

  sync_fifo_fwft #(
    .DATA_WIDTH (16), .ADDR_SIZE (4), .FWFT (1), .AFULL_THRESH (14), .AEMPTY_THRESH (2)
  ) dut1 (
    .clk (clk), .rstn (rstn), .flush (flush), .wr_en (wr_en), .din (din), .rd_en (rd_en),
    .dout (dout1), .full (full1), .empty (empty1), .almost_full (af1), .almost_empty (ae1),
    .count (count1), .overflow (ovf1), .underflow (unf1), .err_clr (err_clr)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  logic        movf = 1'b0;
  logic        munf = 1'b0;
  logic        pend0 = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Standard mode: the popped word appears on dout in the cycle after the accepting edge.
  always @(negedge clk) begin
    if (pend0) begin
      pend0 = 1'b0;
      total++;
      if (exp0.size() == 0) begin
        bad++;
        $display("FAIL std_unexpected_read: got dout=%0h expected no read at %0t", dout0, $time);
      end else begin
        logic [15:0] e;
        e = exp0.pop_front();
        if (dout0 != e) begin
          bad++;
          $display("FAIL std_dout: got %0h expected %0h at %0t", dout0, e, $time);
        end
      end
    end
    if (rstn && !flush && rd_en && !empty0) pend0 = 1'b1;
  end

  // FWFT mode: the presented word is checked when the pop is handshaked.
  always @(negedge clk) begin
    if (rstn && !flush && rd_en && !empty1) begin
      total++;
      if (exp1.size() == 0) begin
        bad++;
        $display("FAIL fwft_unexpected_read: got dout=%0h expected no read at %0t", dout1, $time);
      end else begin
        logic [15:0] e;
        e = exp1.pop_front();
        if (dout1 != e) begin
          bad++;
          $display("FAIL fwft_dout: got %0h expected %0h at %0t", dout1, e, $time);
        end
      end
    end
  end

  task automatic step(input logic we, input logic [15:0] d, input logic re,
                      input logic fl = 1'b0, input logic ec = 1'b0);
    int sz;
    logic [15:0] v;
    sz      = mq.size();
    wr_en   = we;
    din     = d;
    rd_en   = re;
    flush   = fl;
    err_clr = ec;
    if (fl) begin
      mq.delete();
    end else begin
      if (re && sz > 0) begin
        v = mq.pop_front();
        exp0.push_back(v);
        exp1.push_back(v);
      end
      if (we && sz < 16) mq.push_back(d);
    end
    if (!fl && we && sz == 16) movf = 1'b1;
    else if (ec)               movf = 1'b0;
    if (!fl && re && sz == 0)  munf = 1'b1;
    else if (ec)               munf = 1'b0;
    @(posedge clk);
    #1;
    sz = mq.size();
    chk("count0", int'(count0), sz);
    chk("empty0", int'(empty0), int'(sz == 0));
    chk("full0",  int'(full0),  int'(sz == 16));
    chk("afull0", int'(af0),    int'(sz >= 14));
    chk("aempty0", int'(ae0),   int'(sz <= 2));
    chk("ovf0",   int'(ovf0),   int'(movf));
    chk("unf0",   int'(unf0),   int'(munf));
    chk("count1", int'(count1), sz);
    chk("empty1", int'(empty1), int'(sz == 0));
    chk("ovf1",   int'(ovf1),   int'(movf));
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty",  int'(empty0), 1);
    chk("rst_aempty", int'(ae0),    1);
    chk("rst_count",  int'(count0), 0);
    chk("rst_dout",   int'(dout0),  0);
    chk("rst_full",   int'(full0),  0);
    chk("rst_ovf",    int'(ovf0),   0);
    chk("rst_unf",    int'(unf0),   0);
    rstn = 1'b1;
    idle();

    // Fill, overflow, drain, underflow.
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b1, 16'hDEAD, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // FWFT word presented without rd_en.
    step(1'b1, 16'hA5A5, 1'b0);
    idle();
    chk("fwft_present", int'(dout1), 16'hA5A5);
    step(1'b0, 16'h0, 1'b1);
    idle();

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < 16; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0);
    step(1'b1, 16'hBAD0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h5A5A, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Streaming at occupancy 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 16'h3000 + 16'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);

    // Flush with both error flags set and a write in the same cycle.
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0);
    step(1'b1, 16'hBAD1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b1);
    chk("pre_flush_count", int'(count0), 9);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("flush_ovf_kept", int'(ovf0), 1);
    chk("flush_unf_kept", int'(unf0), 1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("errclr_ovf", int'(ovf0), 0);
    chk("errclr_unf", int'(unf0), 0);
    idle();
    idle();

    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, parametrised FIFO for buffering AXI channel payloads inside the crossbar where both sides share one clock. It generalises our dual-clock FIFO:
- no pointer synchronisation;
- selectable standard or first-word-fall-through (FWFT) read mode;
- occupancy count with programmable almost-full/almost-empty thresholds;
- synchronous flush;
- sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 16, payload width in bits
- ADDR_SIZE, 4, address bits; DEPTH = 2**ADDR_SIZE entries
- FWFT, 0, 0 = standard read (registered dout), 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-2, almost_full asserted when count >= this value
- AEMPTY_THRESH, 2, almost_empty asserted when count <= this value

Ports:
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read/pop request
- dout  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  clears overflow/underflow

## Operation
- Pointers: wr_ptr and rd_ptr, each ADDR_SIZE+1 bits binary.
  - The low ADDR_SIZE bits address memory; the MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_SIZE+1).
  - full: low bits equal and MSBs differ. empty: pointers equal.
- Write accepted = wr_en & ~full: mem[wr_ptr] <= din; wr_ptr++.
  - wr_en & full: data dropped, pointer held, overflow <= 1.
- Read accepted = rd_en & ~empty: rd_ptr++.
  - rd_en & empty: no pointer change, underflow <= 1.
- Simultaneous accepted read and write: both pointers advance; count unchanged.
  - When full, the write is still refused even if a read occurs in the same cycle. The full flag is evaluated at the start of the cycle.
  - When empty, the write is accepted and the read is refused.
- FWFT=0: on an accepted read, dout <= mem[rd_ptr] at that edge. Otherwise dout holds its last value.
- FWFT=1: dout = mem[rd_ptr] combinationally while ~empty. rd_en acknowledges (pops) the presented word. dout is don't-care while empty.
- Priority per cycle: rstn (low), then flush, then wr/rd.
  - flush: both pointers <= 0. dout holds. Errors are untouched. wr_en and rd_en in the same cycle are ignored and set no error flags.
- err_clr: overflow/underflow <= 0. A new error event in the same cycle wins; the flag stays 1.
- Flags and count are decoded from the registered pointers, so they change only at clock edges.

## Timing
- Reset values (rstn low at a rising edge):
  - pointers, count, dout, full, almost_full, overflow, underflow = 0
  - empty = 1, almost_empty = 1 (given AEMPTY_THRESH >= 0)
  - memory contents are not reset
- Write-to-empty-deassert: empty falls the cycle after the accepted write edge.
  - FWFT=1: the word is valid on dout in that same cycle.
  - FWFT=0: data appears on dout one cycle after the accepted rd_en edge.
- full rises the cycle after the write that makes count == DEPTH. It falls the cycle after any accepted read.
- Back-to-back: one write and one read per cycle are sustainable indefinitely at any occupancy 1..DEPTH-1.
- Wrap-around: after 2*DEPTH writes/reads the pointers return to 0 with no glitch on count or flags.
- rstn or flush mid-burst: contents are discarded at that edge. The next cycle shows empty = 1, count = 0.

## Structure
- Package sync_fifo_pkg holds:
  - localparam helper function for DEPTH (2**ADDR_SIZE)
  - FWFT mode constants (FIFO_STD = 0, FIFO_FWFT = 1)
- One sub-module: sync_fifo_mem. It is a register-array memory with DEPTH x DATA_WIDTH entries, one synchronous write port and an asynchronous read port. The FWFT/standard output stage stays in the top.
- Elaboration check: AEMPTY_THRESH < AFULL_THRESH <= DEPTH.

## Test plan
- Reset with DATA_WIDTH=16, ADDR_SIZE=4, FWFT=0: after rstn low then high, expect empty=1, almost_empty=1, count=0, dout=0, full=0.
- Fill/drain: write 0x0000..0x000F (16 words).
  - Expect full=1 and count=16, with almost_full rising at count 14.
  - A 17th write sets overflow=1, with count still 16.
  - Reading 16 words returns 0x0000..0x000F in order, with dout one cycle after each rd_en.
  - A 17th read sets underflow=1.
- FWFT=1: single write of 0xA5A5 to an empty FIFO.
  - The next cycle shows empty=0 and dout=0xA5A5 with no rd_en.
  - An rd_en pulse then gives empty=1 the following cycle.
- Simultaneous: at count=16 assert wr_en and rd_en together. The read is accepted, the write is refused, overflow=1 and count=15.
  - At count=0 the same stimulus gives count=1, underflow=1.
- Wrap: stream 100 words at continuous rd/wr with occupancy held at 3. Data integrity holds and count stays 3 throughout the pointer wrap.
- Flush with count=9 and wr_en=1 in the same cycle: the next cycle shows count=0, empty=1, and overflow/underflow unchanged.
  - A following err_clr pulse clears both flags.
